// File: rtl/burst_initiator_pkg.sv
// Shared constants, FSM state type and command-length rule for the burst initiator.
package burst_initiator_pkg;
  localparam int ADDR_WIDTH = 8;
  localparam int DATA_WIDTH = 8;
  localparam int BURST_LEN  = 8;
  localparam int RD_LAT     = 1;
  localparam int LEN_W      = $clog2(BURST_LEN) + 1;
  localparam int IDX_W      = $clog2(BURST_LEN);

  localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(BURST_LEN);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    WR_FILL  = 3'd1,
    WR_BURST = 3'd2,
    RD_BURST = 3'd3,
    RD_DRAIN = 3'd4
  } state_t;

  function automatic logic len_legal(input logic [LEN_W-1:0] len);
    return (len != '0) && (len <= MAX_LEN);
  endfunction
endpackage

// File: rtl/burst_initiator_if.sv
// Command, write-data, read-data and target-side signals of the burst initiator.
// A valid/ready pair transfers one item on every rising edge where both are high; valid may
// not depend on ready. rdata_valid has no ready and must be taken when it is high.
interface burst_initiator_if;
  import burst_initiator_pkg::*;

  logic                  cmd_valid;
  logic                  cmd_ready;
  logic                  cmd_write;
  logic [ADDR_WIDTH-1:0] cmd_addr;
  logic [LEN_W-1:0]      cmd_len;
  logic                  wdata_valid;
  logic                  wdata_ready;
  logic [DATA_WIDTH-1:0] wdata;
  logic                  rdata_valid;
  logic [DATA_WIDTH-1:0] rdata;
  logic                  done;
  logic                  err;
  logic [ADDR_WIDTH-1:0] addr_top;
  logic                  burst_en;
  logic                  wren;
  logic                  rden;
  logic [DATA_WIDTH-1:0] wr_data;
  logic [DATA_WIDTH-1:0] rd_data;

  // master: the initiator itself; slave: the command source plus the memory target
  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_len, wdata_valid, wdata, rd_data,
    output cmd_ready, wdata_ready, rdata_valid, rdata, done, err,
           addr_top, burst_en, wren, rden, wr_data
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_len, wdata_valid, wdata, rd_data,
    input  cmd_ready, wdata_ready, rdata_valid, rdata, done, err,
           addr_top, burst_en, wren, rden, wr_data
  );
endinterface

// File: rtl/burst_initiator_wbuf.sv
// Write-beat buffer: filled by write index, replayed by beat index during the write burst.
module burst_initiator_wbuf
  import burst_initiator_pkg::*;
(
  input  logic                  clk,
  input  logic                  we,
  input  logic [IDX_W-1:0]      waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [IDX_W-1:0]      raddr,
  output logic [DATA_WIDTH-1:0] rdata
);
  logic [DATA_WIDTH-1:0] mem [BURST_LEN];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];
endmodule

// File: rtl/burst_initiator.sv
// Burst initiator: takes read/write commands, buffers write beats, drives the burst target
// and returns read data through a latency-matched valid pipe.
module burst_initiator
  import burst_initiator_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  burst_initiator_if.master bus,
  output state_t            dbg_state
);
  state_t                state;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [LEN_W-1:0]      len_q;
  logic [LEN_W-1:0]      beat_cnt;
  logic [LEN_W-1:0]      fill_cnt;
  logic                  err_q;
  logic [RD_LAT-1:0]     rv_pipe;
  logic [RD_LAT-1:0]     last_pipe;
  logic                  wr_active;
  logic                  rd_active;
  logic                  last_beat;
  logic                  buf_we;
  logic [DATA_WIDTH-1:0] buf_rdata;

  assign wr_active = (state == WR_BURST);
  assign rd_active = (state == RD_BURST);
  assign last_beat = (beat_cnt == len_q - 1'b1);
  assign buf_we    = (state == WR_FILL) && bus.wdata_valid;

  burst_initiator_wbuf u_wbuf (
    .clk   (clk),
    .we    (buf_we),
    .waddr (fill_cnt[IDX_W-1:0]),
    .wdata (bus.wdata),
    .raddr (beat_cnt[IDX_W-1:0]),
    .rdata (buf_rdata)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      addr_q    <= '0;
      len_q     <= '0;
      beat_cnt  <= '0;
      fill_cnt  <= '0;
      err_q     <= 1'b0;
      rv_pipe   <= '0;
      last_pipe <= '0;
    end else begin
      err_q        <= 1'b0;
      // last_pipe tags the final read beat so done lands on its rdata_valid
      rv_pipe[0]   <= rd_active;
      last_pipe[0] <= rd_active && last_beat;
      for (int i = 1; i < RD_LAT; i++) begin
        rv_pipe[i]   <= rv_pipe[i-1];
        last_pipe[i] <= last_pipe[i-1];
      end

      case (state)
        IDLE: begin
          if (bus.cmd_valid) begin
            addr_q   <= bus.cmd_addr;
            len_q    <= bus.cmd_len;
            beat_cnt <= '0;
            fill_cnt <= '0;
            if (!len_legal(bus.cmd_len)) err_q <= 1'b1;
            else if (bus.cmd_write)      state <= WR_FILL;
            else                         state <= RD_BURST;
          end
        end
        WR_FILL: begin
          if (bus.wdata_valid) begin
            fill_cnt <= fill_cnt + 1'b1;
            if (fill_cnt == len_q - 1'b1) state <= WR_BURST;
          end
        end
        WR_BURST: begin
          if (last_beat) state <= IDLE;
          else           beat_cnt <= beat_cnt + 1'b1;
        end
        RD_BURST: begin
          if (last_beat) state <= RD_DRAIN;
          else           beat_cnt <= beat_cnt + 1'b1;
        end
        RD_DRAIN: begin
          if (last_pipe[RD_LAT-1]) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Target outputs decode only registered state, so all are 0 outside the two burst states
  assign bus.wren        = wr_active;
  assign bus.rden        = rd_active;
  assign bus.burst_en    = (wr_active || rd_active) && (len_q > LEN_W'(1));
  assign bus.addr_top    = (wr_active || rd_active) ? addr_q : '0;
  assign bus.wr_data     = wr_active ? buf_rdata : '0;
  assign bus.cmd_ready   = (state == IDLE);
  assign bus.wdata_ready = (state == WR_FILL);
  assign bus.rdata_valid = rv_pipe[RD_LAT-1];
  assign bus.rdata       = rv_pipe[RD_LAT-1] ? bus.rd_data : '0;
  assign bus.done        = (wr_active && last_beat) || last_pipe[RD_LAT-1];
  assign bus.err         = err_q;
  assign dbg_state       = state;
endmodule

// File: tb/tb_burst_initiator.sv
// Bench for burst_initiator: memory target model, bus monitor, reference memory and scenarios.
module tb_burst_initiator;
  import burst_initiator_pkg::*;

  logic   clk = 1'b0;
  logic   rst;
  state_t dbg_state;
  int     checks = 0;
  int     failures = 0;

  burst_initiator_if bif ();

  burst_initiator dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bif),
    .dbg_state (dbg_state)
  );

  always #5 clk = ~clk;

  // Memory target: start address plus an offset that advances while burst_en is high
  logic [DATA_WIDTH-1:0] tgt_mem [256];
  logic [ADDR_WIDTH-1:0] tgt_off;
  logic [DATA_WIDTH-1:0] tgt_rd;
  assign bif.rd_data = tgt_rd;

  always @(posedge clk) begin
    if (rst) begin
      tgt_off <= '0;
      tgt_rd  <= '0;
      for (int i = 0; i < 256; i++) tgt_mem[i] <= 8'(i) ^ 8'h5A;
    end else if (bif.wren || bif.rden) begin
      if (bif.wren) tgt_mem[bif.addr_top + tgt_off] <= bif.wr_data;
      if (bif.rden) tgt_rd <= tgt_mem[bif.addr_top + tgt_off];
      tgt_off <= bif.burst_en ? tgt_off + 8'd1 : 8'd0;
    end else begin
      tgt_off <= '0;
    end
  end

  // Reference memory: contents implied by every completed write command
  logic [DATA_WIDTH-1:0] ref_mem [256];
  logic [DATA_WIDTH-1:0] wbeats [BURST_LEN];
  logic [DATA_WIDTH-1:0] exp_q [$];

  // Monitor
  int                    cyc = 0;
  logic [ADDR_WIDTH-1:0] wr_addr_q [$];
  logic [DATA_WIDTH-1:0] wr_data_q [$];
  logic                  wr_be_q [$];
  int                    wr_cyc_q [$];
  logic                  rd_be_q [$];
  int                    rd_cyc_q [$];
  logic [DATA_WIDTH-1:0] rv_data_q [$];
  int                    rv_cyc_q [$];
  int                    done_cyc_q [$];
  int                    err_n = 0;
  int                    both_n = 0;
  int                    idle_viol = 0;
  int                    run = 0;
  int                    max_run = 0;

  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      run = 0;
    end else begin
      if (bif.wren) begin
        wr_addr_q.push_back(bif.addr_top);
        wr_data_q.push_back(bif.wr_data);
        wr_be_q.push_back(bif.burst_en);
        wr_cyc_q.push_back(cyc);
      end
      if (bif.rden) begin
        rd_be_q.push_back(bif.burst_en);
        rd_cyc_q.push_back(cyc);
      end
      if (bif.rdata_valid) begin
        rv_data_q.push_back(bif.rdata);
        rv_cyc_q.push_back(cyc);
      end
      if (bif.done) done_cyc_q.push_back(cyc);
      if (bif.err) err_n++;
      if (bif.wren && bif.rden) both_n++;
      if (!bif.wren && !bif.rden && (bif.burst_en || bif.addr_top != '0 || bif.wr_data != '0))
        idle_viol++;
      if (bif.burst_en) begin
        run++;
        if (run > max_run) max_run = run;
      end else begin
        run = 0;
      end
    end
  end

  task automatic clear_obs();
    wr_addr_q.delete(); wr_data_q.delete(); wr_be_q.delete(); wr_cyc_q.delete();
    rd_be_q.delete(); rd_cyc_q.delete(); rv_data_q.delete(); rv_cyc_q.delete();
    done_cyc_q.delete(); exp_q.delete();
    err_n = 0;
    max_run = 0;
  endtask

  // Drivers
  task automatic send_cmd(input logic w, input logic [ADDR_WIDTH-1:0] a,
                          input logic [LEN_W-1:0] l, output bit ok);
    ok = 0;
    bif.cmd_valid = 1'b1; bif.cmd_write = w; bif.cmd_addr = a; bif.cmd_len = l;
    for (int i = 0; i < 60 && !ok; i++) begin
      @(negedge clk);
      if (bif.cmd_ready) ok = 1;
      @(posedge clk); #1;
    end
    bif.cmd_valid = 1'b0;
  endtask

  task automatic send_beats(input int len, input int gap_at, input int gap_len, output bit ok);
    bit acc;
    ok = 1;
    for (int b = 0; b < len; b++) begin
      acc = 0;
      if (b == gap_at) begin
        bif.wdata_valid = 1'b0;
        repeat (gap_len) begin @(posedge clk); #1; end
      end
      bif.wdata_valid = 1'b1;
      bif.wdata = wbeats[b];
      for (int i = 0; i < 60 && !acc; i++) begin
        @(negedge clk);
        if (bif.wdata_ready) acc = 1;
        @(posedge clk); #1;
      end
      if (!acc) ok = 0;
    end
    bif.wdata_valid = 1'b0;
  endtask

  task automatic wait_done(output bit ok);
    ok = 0;
    for (int i = 0; i < 60 && !ok; i++) begin
      @(negedge clk);
      if (bif.done) ok = 1;
    end
    @(posedge clk); #1;
  endtask

  // Scenarios
  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({bif.wren, bif.rden, bif.burst_en, bif.addr_top, bif.wr_data, bif.wdata_ready,
         bif.rdata_valid, bif.done, bif.err} !== '0) begin
      failures++;
      $display("FAIL reset_outputs: wren=%b rden=%b burst_en=%b addr_top=%h wr_data=%h, required all 0",
               bif.wren, bif.rden, bif.burst_en, bif.addr_top, bif.wr_data);
    end
    checks++;
    if (bif.cmd_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_cmd_ready: got %b required 1", bif.cmd_ready);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (bif.cmd_ready !== 1'b1 || bif.wren !== 1'b0 || bif.rden !== 1'b0) begin
      failures++;
      $display("FAIL reset_release: cmd_ready=%b wren=%b rden=%b required 1/0/0",
               bif.cmd_ready, bif.wren, bif.rden);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_single_write();
    bit ok1, ok2, ok3;
    clear_obs();
    wbeats[0] = 8'hA5;
    send_cmd(1'b1, 8'h05, LEN_W'(1), ok1);
    send_beats(1, -1, 0, ok2);
    wait_done(ok3);
    checks++;
    if (!(ok1 && ok2 && ok3)) begin
      failures++;
      $display("FAIL single_write_timeout: cmd=%b beats=%b done=%b required 1/1/1", ok1, ok2, ok3);
    end
    checks++;
    if (wr_addr_q.size() != 1) begin
      failures++;
      $display("FAIL single_write_beats: got %0d required 1", wr_addr_q.size());
    end
    checks++;
    if (wr_addr_q[0] !== 8'h05 || wr_data_q[0] !== 8'hA5 || wr_be_q[0] !== 1'b0) begin
      failures++;
      $display("FAIL single_write_beat: addr=%h data=%h burst_en=%b required 05/a5/0",
               wr_addr_q[0], wr_data_q[0], wr_be_q[0]);
    end
    checks++;
    if (done_cyc_q.size() != 1 || done_cyc_q[0] != wr_cyc_q[0]) begin
      failures++;
      $display("FAIL single_write_done: done pulses=%0d required 1 on the wren beat", done_cyc_q.size());
    end
    ref_mem[8'h05] = 8'hA5;
  endtask

  task automatic test_burst_write();
    bit ok1, ok2, ok3;
    clear_obs();
    for (int i = 0; i < 4; i++) wbeats[i] = 8'h17 + 8'(i);
    send_cmd(1'b1, 8'h07, LEN_W'(4), ok1);
    send_beats(4, 2, 2, ok2);
    wait_done(ok3);
    checks++;
    if (!(ok1 && ok2 && ok3) || wr_addr_q.size() != 4) begin
      failures++;
      $display("FAIL burst_write_count: beats=%0d required 4 (cmd=%b data=%b done=%b)",
               wr_addr_q.size(), ok1, ok2, ok3);
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (wr_addr_q[i] !== 8'h07 || wr_data_q[i] !== wbeats[i] || wr_be_q[i] !== 1'b1 ||
          wr_cyc_q[i] != wr_cyc_q[0] + i) begin
        failures++;
        $display("FAIL burst_write_beat%0d: addr=%h data=%h burst_en=%b required 07/%h/1 contiguous",
                 i, wr_addr_q[i], wr_data_q[i], wr_be_q[i], wbeats[i]);
      end
    end
    checks++;
    if (done_cyc_q.size() != 1 || done_cyc_q[0] != wr_cyc_q[3]) begin
      failures++;
      $display("FAIL burst_write_done: done pulses=%0d required 1 on last beat", done_cyc_q.size());
    end
    for (int i = 0; i < 4; i++) ref_mem[8'h07 + 8'(i)] = wbeats[i];
  endtask

  task automatic test_burst_read();
    bit ok1, ok2;
    clear_obs();
    for (int i = 0; i < 4; i++) exp_q.push_back(ref_mem[8'h07 + 8'(i)]);
    send_cmd(1'b0, 8'h07, LEN_W'(4), ok1);
    wait_done(ok2);
    checks++;
    if (!(ok1 && ok2) || rd_cyc_q.size() != 4 || rv_data_q.size() != 4) begin
      failures++;
      $display("FAIL burst_read_count: rden=%0d rdata_valid=%0d required 4/4", rd_cyc_q.size(),
               rv_data_q.size());
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (rv_data_q[i] !== exp_q[i] || rv_cyc_q[i] != rd_cyc_q[i] + RD_LAT || rd_be_q[i] !== 1'b1) begin
        failures++;
        $display("FAIL burst_read_beat%0d: rdata=%h required %h, latency=%0d required %0d",
                 i, rv_data_q[i], exp_q[i], rv_cyc_q[i] - rd_cyc_q[i], RD_LAT);
      end
    end
    checks++;
    if (done_cyc_q.size() != 1 || done_cyc_q[0] != rv_cyc_q[3]) begin
      failures++;
      $display("FAIL burst_read_done: done pulses=%0d required 1 on last rdata_valid", done_cyc_q.size());
    end
  endtask

  task automatic test_illegal_len();
    bit ok;
    int lens [2];
    lens[0] = 0;
    lens[1] = BURST_LEN + 1;
    for (int k = 0; k < 2; k++) begin
      clear_obs();
      send_cmd(1'b1, 8'h20, LEN_W'(lens[k]), ok);
      @(negedge clk);
      checks++;
      if (!ok || bif.err !== 1'b1 || bif.cmd_ready !== 1'b1) begin
        failures++;
        $display("FAIL illegal_len%0d_err: err=%b cmd_ready=%b required 1/1", lens[k], bif.err,
                 bif.cmd_ready);
      end
      repeat (3) @(negedge clk);
      checks++;
      if (err_n != 1 || wr_cyc_q.size() != 0 || rd_cyc_q.size() != 0 || bif.cmd_ready !== 1'b1) begin
        failures++;
        $display("FAIL illegal_len%0d_quiet: err pulses=%0d wren=%0d rden=%0d required 1/0/0",
                 lens[k], err_n, wr_cyc_q.size(), rd_cyc_q.size());
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_max_len();
    bit ok1, ok2, ok3, ok4, ok5;
    clear_obs();
    for (int i = 0; i < BURST_LEN; i++) wbeats[i] = 8'($urandom_range(0, 255));
    send_cmd(1'b1, 8'hFC, MAX_LEN, ok1);
    send_beats(BURST_LEN, $urandom_range(0, BURST_LEN - 1), 1, ok2);
    wait_done(ok3);
    for (int i = 0; i < BURST_LEN; i++) ref_mem[8'hFC + 8'(i)] = wbeats[i];
    checks++;
    if (!(ok1 && ok2 && ok3) || wr_cyc_q.size() != BURST_LEN || max_run != BURST_LEN) begin
      failures++;
      $display("FAIL max_len_write: beats=%0d burst_en run=%0d required %0d/%0d",
               wr_cyc_q.size(), max_run, BURST_LEN, BURST_LEN);
    end
    clear_obs();
    for (int i = 0; i < BURST_LEN; i++) exp_q.push_back(ref_mem[8'hFC + 8'(i)]);
    send_cmd(1'b0, 8'hFC, MAX_LEN, ok4);
    wait_done(ok5);
    checks++;
    if (!(ok4 && ok5) || rv_data_q.size() != BURST_LEN || max_run != BURST_LEN) begin
      failures++;
      $display("FAIL max_len_read: beats=%0d burst_en run=%0d required %0d/%0d",
               rv_data_q.size(), max_run, BURST_LEN, BURST_LEN);
    end
    for (int i = 0; i < BURST_LEN; i++) begin
      checks++;
      if (rv_data_q[i] !== exp_q[i]) begin
        failures++;
        $display("FAIL max_len_rdata%0d: got %h required %h", i, rv_data_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    bit ok1, ok2, ok3, ok4;
    clear_obs();
    for (int i = 0; i < 3; i++) wbeats[i] = 8'($urandom_range(0, 255));
    send_cmd(1'b1, 8'h40, LEN_W'(3), ok1);
    send_beats(3, -1, 0, ok2);
    for (int i = 0; i < 3; i++) begin
      ref_mem[8'h40 + 8'(i)] = wbeats[i];
      exp_q.push_back(wbeats[i]);
    end
    send_cmd(1'b0, 8'h40, LEN_W'(3), ok3);
    wait_done(ok4);
    checks++;
    if (!(ok1 && ok2 && ok3 && ok4) || wr_cyc_q.size() != 3 || rd_cyc_q.size() != 3) begin
      failures++;
      $display("FAIL b2b_count: wren=%0d rden=%0d required 3/3", wr_cyc_q.size(), rd_cyc_q.size());
    end
    checks++;
    if (rd_cyc_q[0] - wr_cyc_q[2] < 2) begin
      failures++;
      $display("FAIL b2b_gap: burst_en low cycles=%0d required >=1", rd_cyc_q[0] - wr_cyc_q[2] - 1);
    end
    checks++;
    if (done_cyc_q.size() != 2 || both_n != 0) begin
      failures++;
      $display("FAIL b2b_done: done pulses=%0d wren&rden=%0d required 2/0", done_cyc_q.size(), both_n);
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (rv_data_q[i] !== exp_q[i]) begin
        failures++;
        $display("FAIL b2b_rdata%0d: got %h required %h", i, rv_data_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_random();
    bit ok1, ok2, ok3;
    logic w;
    logic [ADDR_WIDTH-1:0] a;
    int l;
    for (int n = 0; n < 30; n++) begin
      clear_obs();
      w = 1'($urandom_range(0, 1));
      a = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 7) == 0) l = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(BURST_LEN + 1, 15);
      else l = $urandom_range(1, BURST_LEN);
      send_cmd(w, a, LEN_W'(l), ok1);
      if (l == 0 || l > BURST_LEN) begin
        repeat (3) @(negedge clk);
        checks++;
        if (!ok1 || err_n != 1 || wr_cyc_q.size() != 0 || rd_cyc_q.size() != 0) begin
          failures++;
          $display("FAIL rand%0d_illegal: err pulses=%0d activity=%0d required 1/0", n, err_n,
                   wr_cyc_q.size() + rd_cyc_q.size());
        end
        @(posedge clk); #1;
      end else if (w) begin
        for (int i = 0; i < l; i++) wbeats[i] = 8'($urandom_range(0, 255));
        send_beats(l, $urandom_range(0, l - 1), $urandom_range(0, 3), ok2);
        wait_done(ok3);
        checks++;
        if (!(ok1 && ok2 && ok3) || wr_cyc_q.size() != l || done_cyc_q.size() != 1 ||
            done_cyc_q[0] != wr_cyc_q[l-1]) begin
          failures++;
          $display("FAIL rand%0d_write_shape: beats=%0d required %0d, done pulses=%0d", n,
                   wr_cyc_q.size(), l, done_cyc_q.size());
        end
        for (int i = 0; i < l; i++) begin
          checks++;
          if (wr_addr_q[i] !== a || wr_data_q[i] !== wbeats[i] || wr_be_q[i] !== (l > 1) ||
              wr_cyc_q[i] != wr_cyc_q[0] + i) begin
            failures++;
            $display("FAIL rand%0d_wbeat%0d: addr=%h data=%h be=%b required %h/%h/%b", n, i,
                     wr_addr_q[i], wr_data_q[i], wr_be_q[i], a, wbeats[i], l > 1);
          end
          ref_mem[a + 8'(i)] = wbeats[i];
        end
      end else begin
        for (int i = 0; i < l; i++) exp_q.push_back(ref_mem[a + 8'(i)]);
        wait_done(ok3);
        checks++;
        if (!(ok1 && ok3) || rv_data_q.size() != l || done_cyc_q.size() != 1 ||
            done_cyc_q[0] != rv_cyc_q[l-1]) begin
          failures++;
          $display("FAIL rand%0d_read_shape: beats=%0d required %0d, done pulses=%0d", n,
                   rv_data_q.size(), l, done_cyc_q.size());
        end
        for (int i = 0; i < l; i++) begin
          checks++;
          if (rv_data_q[i] !== exp_q[i] || rd_be_q[i] !== (l > 1) || rv_cyc_q[i] != rd_cyc_q[i] + RD_LAT) begin
            failures++;
            $display("FAIL rand%0d_rbeat%0d: rdata=%h required %h, be=%b required %b", n, i,
                     rv_data_q[i], exp_q[i], rd_be_q[i], l > 1);
          end
        end
      end
    end
  endtask

  task automatic test_reset_mid_burst();
    bit ok1, ok2, seen;
    clear_obs();
    for (int i = 0; i < 4; i++) wbeats[i] = 8'hC0 + 8'(i);
    send_cmd(1'b1, 8'hC0, LEN_W'(4), ok1);
    send_beats(4, -1, 0, ok2);
    seen = 0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      if (bif.wren) seen = 1;
    end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (!(ok1 && ok2 && seen) || bif.wren !== 1'b0 || bif.burst_en !== 1'b0 || bif.rden !== 1'b0 ||
        bif.cmd_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_mid_burst: wren=%b burst_en=%b cmd_ready=%b required 0/0/1 (burst seen=%b)",
               bif.wren, bif.burst_en, bif.cmd_ready, seen);
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (bif.cmd_ready !== 1'b1 || bif.done !== 1'b0 || bif.wren !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid_burst_after: cmd_ready=%b done=%b wren=%b required 1/0/0",
               bif.cmd_ready, bif.done, bif.wren);
    end
  endtask

  initial begin
    bif.cmd_valid = 1'b0; bif.cmd_write = 1'b0; bif.cmd_addr = '0; bif.cmd_len = '0;
    bif.wdata_valid = 1'b0; bif.wdata = '0;
    for (int i = 0; i < 256; i++) ref_mem[i] = 8'(i) ^ 8'h5A;
    test_reset();
    test_single_write();
    test_burst_write();
    test_burst_read();
    test_illegal_len();
    test_max_len();
    test_back_to_back();
    test_random();
    checks++;
    if (both_n != 0 || idle_viol != 0) begin
      failures++;
      $display("FAIL bus_rules: wren&rden cycles=%0d idle-nonzero cycles=%0d required 0/0", both_n,
               idle_viol);
    end
    test_reset_mid_burst();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not complete, required completion");
    $fatal(1, "timeout");
  end
endmodule
